sysbus_mem_responder: RTL and testbench
=======================================

SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 Parameter BUS_DATA_WIDTH SHALL default to 64 and set the width of the request/response data buses.
REQ-002 Parameter BUS_TAG_WIDTH SHALL default to 13 and set the width of the request/response tags.
REQ-003 Parameter MEM_WORDS SHALL default to 4096 and set the number of 64-bit words in backing storage.
REQ-004 Parameter READ_LATENCY SHALL default to 2 and set the cycles from the reqack pulse to the first response beat (legal range 1..15).
REQ-005 Port clk SHALL be an input of width 1 and serve as the single clock.
REQ-006 Port reset SHALL be an input of width 1 and serve as a synchronous, active-high reset.
REQ-007 Port bus_reqcyc SHALL be an input of width 1 that is high while the requester presents a request or write-data beat.
REQ-008 Port bus_req SHALL be an input of width BUS_DATA_WIDTH carrying the byte address in the request cycle and write data in write-data beats.
REQ-009 Port bus_reqtag SHALL be an input of width BUS_TAG_WIDTH where bit 12 carries READ/WRITE and bits 11:8 carry the device code.
REQ-010 Port bus_reqack SHALL be an output of width 1 that pulses once to acknowledge acceptance of a request.
REQ-011 Port bus_respcyc SHALL be an output of width 1 that is high while a response beat is valid.
REQ-012 Port bus_resp SHALL be an output of width BUS_DATA_WIDTH carrying response data.
REQ-013 Port bus_resptag SHALL be an output of width BUS_TAG_WIDTH that echoes the accepted request tag.
REQ-014 Port bus_respack SHALL be an input of width 1 on which the requester acknowledges the current response beat.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, ACK, LAT, RESP and WDATA.
REQ-016 In IDLE, when bus_reqcyc is sampled high, the block SHALL latch bus_req, latch bus_reqtag and go to ACK.
REQ-017 In ACK, bus_reqack SHALL be high for exactly one cycle; the next state SHALL be WDATA for a WRITE tag and LAT otherwise.
REQ-018 Outside IDLE, the block SHALL ignore bus_reqcyc except in WDATA; the requester holds bus_reqcyc until it sees bus_reqack.
REQ-019 Line address: the block SHALL ignore address bits [5:0] and SHALL form the base word index as (addr[63:6]*8) mod MEM_WORDS.
REQ-020 Beat k (k = 0..7) SHALL use word index (base + k) mod MEM_WORDS, so indices wrap past the top of memory.
REQ-021 LAT SHALL last READ_LATENCY cycles, counted by a 4-bit down-counter, and then go to RESP.
REQ-022 In RESP, bus_respcyc SHALL be high and bus_resp SHALL hold beat k, and bus_resptag SHALL hold the latched tag.
REQ-023 In RESP, beat k SHALL advance to k+1 on each edge where bus_respcyc and bus_respack are both high.
REQ-024 While bus_respack is low, bus_resp SHALL hold the current beat unchanged.
REQ-025 After beat 7 is acknowledged, the block SHALL drive bus_respcyc low in the next cycle and return to IDLE.
REQ-026 A request arriving in that same return cycle SHALL not be accepted until IDLE samples it.
REQ-027 A read whose device code is not MEMORY SHALL still be acked and answered with 8 beats of zero, and memory SHALL not be accessed.
REQ-028 In WDATA, each edge with bus_reqcyc high SHALL write bus_req to word (base + k) and increment k.
REQ-029 After the 8th write-data beat, the block SHALL go to IDLE without producing any response.
REQ-030 A write with a non-MEMORY device code SHALL consume its 8 beats and discard them.
REQ-031 The beat counter SHALL be 3 bits wide and wrap naturally; burst termination SHALL be determined by count==7 together with the beat handshake.
REQ-032 Memory reads SHALL be registered, with read data valid no later than the cycle bus_respcyc asserts for that beat.

Reset
REQ-033 On reset, the FSM SHALL go to IDLE.
REQ-034 On reset, bus_reqack, bus_respcyc, bus_resp and bus_resptag SHALL all be 0.
REQ-035 On reset, the beat and latency counters SHALL be cleared to 0.
REQ-036 Reset asserted mid-burst SHALL abandon the burst, with no further beats and no partial write completion.
REQ-037 Memory contents SHALL be unaffected by reset.

Structure
REQ-038 Package sysbus_pkg SHALL hold the SYSBUS_READ/WRITE and SYSBUS_MEMORY tag constants, the tag field positions, BEATS_PER_LINE=8 and the FSM state enum.
REQ-039 Storage SHALL be a sub-module sysbus_mem_array with one synchronous read port and one write port, MEM_WORDS deep and 64 bits wide.

Verification
REQ-040 Read burst: preload words 8..15 = 0x100..0x107; issue a read at addr 0x40 with MEMORY tag, respack held high -> reqack pulses once, first beat appears READ_LATENCY cycles later, then 8 consecutive beats 0x100..0x107, all with resptag == reqtag.
REQ-041 Backpressure: repeat the read burst with respack low for 3 cycles at beat 2 -> beat 2 holds 0x102 steady, and the burst completes in order with no lost or duplicated beats.
REQ-042 Wrap-around: read addr (MEM_WORDS-4)*8 -> beats come from words MEM_WORDS-4..MEM_WORDS-1, then 0..3.
REQ-043 Write then read: write 8 beats 0xA0..0xA7 to 0x80, then read 0x80 -> responses 0xA0..0xA7; the write produces no bus_respcyc.
REQ-044 Busy and reset: hold reqcyc during a burst -> no second reqack until IDLE; assert reset at beat 4 -> bus_respcyc is 0 the next cycle and the next request is served normally.
REQ-045 Non-memory device: read with device code 0x3 -> 8 beats of zero with the echoed tag.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared sysbus definitions: tag encodings, tag field positions,
// line geometry and the responder FSM state type.
package sysbus_pkg;

   localparam int TAG_RW_BIT = 12;
   localparam int TAG_DEV_HI = 11;
   localparam int TAG_DEV_LO = 8;

   localparam logic       SYSBUS_READ   = 1'b1;
   localparam logic       SYSBUS_WRITE  = 1'b0;
   localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

   localparam int BEATS_PER_LINE = 8;

   typedef enum logic [2:0] {
      IDLE,
      ACK,
      LAT,
      RESP,
      WDATA
   } state_e;

endpackage

// File: rtl/sysbus_mem_array.sv
// Backing store: WORDS x DW, one registered read port, one write port.
// Ports: clk, rd_en_i/rd_addr_i -> rd_data_o (next cycle), wr_en_i/wr_addr_i/wr_data_i.
module sysbus_mem_array #(
   parameter int WORDS = 4096,
   parameter int DW    = 64,
   parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic          clk,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i
);

   logic [DW-1:0] mem_q [WORDS];
   logic [DW-1:0] rd_data_q;

   // Storage is never reset; contents survive a bus reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory slave: accepts one line request, answers 8-beat reads or
// absorbs 8-beat writes. Ports: clk, reset, bus_req* (in), bus_resp* (out).
module sysbus_mem_responder
   import sysbus_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int MEM_WORDS      = 4096,
   parameter int READ_LATENCY   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_reqack,
   output logic                      bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   input  logic                      bus_respack
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   state_e                     state_q, state_d;
   logic [2:0]                 beat_q, beat_d;
   logic [3:0]                 lat_q, lat_d;
   logic [AW-1:0]              base_q, base_d;
   logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_d;

   logic                       rd_en, wr_en;
   logic [AW-1:0]              rd_addr, wr_addr;
   logic [BUS_DATA_WIDTH-1:0]  rd_data;
   logic [57:0]                req_line;
   logic                       is_mem, is_wr, last_beat;

   // Base word = line * 8, reduced into the array (MEM_WORDS need not be
   // a multiple of 8, so a line may straddle the top of memory).
   function automatic logic [AW-1:0] line_base(input logic [57:0] line);
      logic [63:0] w;
      w = {3'b000, line, 3'b000} % 64'(MEM_WORDS);
      return w[AW-1:0];
   endfunction

   // (base + k) mod MEM_WORDS with base already reduced and k < 8.
   function automatic logic [AW-1:0] word_idx(input logic [AW-1:0] b,
                                               input logic [2:0] k);
      logic [AW:0] s;
      s = {1'b0, b} + (AW+1)'(k);
      if (s >= (AW+1)'(MEM_WORDS)) s = s - (AW+1)'(MEM_WORDS);
      return s[AW-1:0];
   endfunction

   assign req_line  = bus_req[63:6];
   assign is_mem    = (tag_q[TAG_DEV_HI:TAG_DEV_LO] == SYSBUS_MEMORY);
   assign is_wr     = (tag_q[TAG_RW_BIT] == SYSBUS_WRITE);
   assign last_beat = (beat_q == 3'(BEATS_PER_LINE - 1));

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      lat_d   = lat_q;
      base_d  = base_q;
      tag_d   = tag_q;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus_reqcyc) begin
               base_d  = line_base(req_line);
               tag_d   = bus_reqtag;
               beat_d  = 3'd0;
               state_d = ACK;
            end
         end
         ACK: begin
            lat_d   = 4'(READ_LATENCY);
            state_d = is_wr ? WDATA : LAT;
         end
         LAT: begin
            // Prefetch beat 0 so it is registered when RESP starts.
            rd_en = is_mem;
            lat_d = lat_q - 4'd1;
            if (lat_q == 4'd1) state_d = RESP;
         end
         RESP: begin
            rd_en = is_mem;
            if (bus_respack) begin
               beat_d = beat_q + 3'd1;
               if (last_beat) state_d = IDLE;
            end
         end
         WDATA: begin
            if (bus_reqcyc) begin
               wr_en  = is_mem & ~reset;
               beat_d = beat_q + 3'd1;
               if (last_beat) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read the word for the beat shown next cycle; a stall rereads it.
   assign rd_addr = word_idx(base_q, beat_d);
   assign wr_addr = word_idx(base_q, beat_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         beat_q  <= 3'd0;
         lat_q   <= 4'd0;
         base_q  <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         lat_q   <= lat_d;
         base_q  <= base_d;
         tag_q   <= tag_d;
      end
   end

   sysbus_mem_array #(
      .WORDS (MEM_WORDS),
      .DW    (BUS_DATA_WIDTH),
      .AW    (AW)
   ) u_mem (
      .clk       (clk),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (bus_req)
   );

   assign bus_reqack  = (state_q == ACK);
   assign bus_respcyc = (state_q == RESP);
   assign bus_resp    = (bus_respcyc && is_mem) ? rd_data : '0;
   assign bus_resptag = bus_respcyc ? tag_q : '0;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder (60-word store so lines wrap).
// Drives after posedge, samples on negedge.
module tb_sysbus_mem_responder;

   localparam int DW  = 64;
   localparam int TW  = 13;
   localparam int MW  = 60;
   localparam int LAT = 2;

   localparam logic [TW-1:0] TAG_RD  = 13'h1105;
   localparam logic [TW-1:0] TAG_WR  = 13'h0107;
   localparam logic [TW-1:0] TAG_NRD = 13'h1322;
   localparam logic [TW-1:0] TAG_NWR = 13'h0333;

   logic          clk = 1'b0;
   logic          reset;
   logic          bus_reqcyc;
   logic [DW-1:0] bus_req;
   logic [TW-1:0] bus_reqtag;
   logic          bus_reqack;
   logic          bus_respcyc;
   logic [DW-1:0] bus_resp;
   logic [TW-1:0] bus_resptag;
   logic          bus_respack;

   int errors = 0;
   int checks = 0;

   logic [63:0] ev [8];

   always #5 clk = ~clk;

   sysbus_mem_responder #(
      .BUS_DATA_WIDTH (DW),
      .BUS_TAG_WIDTH  (TW),
      .MEM_WORDS      (MW),
      .READ_LATENCY   (LAT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus_reqcyc  (bus_reqcyc),
      .bus_req     (bus_req),
      .bus_reqtag  (bus_reqtag),
      .bus_reqack  (bus_reqack),
      .bus_respcyc (bus_respcyc),
      .bus_resp    (bus_resp),
      .bus_resptag (bus_resptag),
      .bus_respack (bus_respack)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request and return at the negedge where reqack is seen.
   task automatic request(input string nm, input logic [63:0] addr,
                          input logic [TW-1:0] tag);
      int n;
      n = 0;
      bus_reqcyc = 1'b1;
      bus_req    = addr;
      bus_reqtag = tag;
      @(negedge clk);
      while (!bus_reqack && n < 20) begin
         step();
         @(negedge clk);
         n++;
      end
      chk({nm, "_ack"}, 64'(bus_reqack), 64'd1);
   endtask

   task automatic write_line(input string nm, input logic [63:0] addr,
                             input logic [TW-1:0] tag,
                             input logic [63:0] d0);
      request(nm, addr, tag);
      step();
      for (int k = 0; k < 8; k++) begin
         bus_req = d0 + 64'(k);
         @(negedge clk);
         chk({nm, "_wr_norsp"}, 64'(bus_respcyc), 64'd0);
         step();
      end
      bus_reqcyc = 1'b0;
      bus_req    = '0;
      @(negedge clk);
      chk({nm, "_wr_done_rsp"}, 64'(bus_respcyc), 64'd0);
      chk({nm, "_wr_done_ack"}, 64'(bus_reqack), 64'd0);
   endtask

   task automatic read_line(input string nm, input logic [63:0] addr,
                            input logic [TW-1:0] tag,
                            input logic [63:0] exp [8],
                            input int stall_k);
      int lat;
      bus_respack = 1'b1;
      request(nm, addr, tag);
      step();
      bus_reqcyc = 1'b0;
      lat = 0;
      @(negedge clk);
      chk({nm, "_ack_pulse"}, 64'(bus_reqack), 64'd0);
      while (!bus_respcyc && lat < 20) begin
         lat++;
         step();
         @(negedge clk);
      end
      // respcyc stays low for LAT cycles after the ack cycle.
      chk({nm, "_latency"}, 64'(lat), 64'(LAT));
      for (int k = 0; k < 8; k++) begin
         chk({nm, "_cyc"}, 64'(bus_respcyc), 64'd1);
         chk({nm, "_data"}, bus_resp, exp[k]);
         chk({nm, "_tag"}, 64'(bus_resptag), 64'(tag));
         if (k == stall_k) begin
            bus_respack = 1'b0;
            for (int s = 0; s < 3; s++) begin
               step();
               @(negedge clk);
               chk({nm, "_stall_cyc"}, 64'(bus_respcyc), 64'd1);
               chk({nm, "_stall_data"}, bus_resp, exp[k]);
            end
            bus_respack = 1'b1;
         end
         step();
         @(negedge clk);
      end
      chk({nm, "_end"}, 64'(bus_respcyc), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;
      int beats;
      int n;
      reset       = 1'b1;
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("rst_reqack", 64'(bus_reqack), 64'd0);
      chk("rst_respcyc", 64'(bus_respcyc), 64'd0);
      chk("rst_resp", bus_resp, 64'd0);
      chk("rst_resptag", 64'(bus_resptag), 64'd0);
      step();
      reset = 1'b0;
      step();

      // Line at 0x40 -> words 8..15.
      write_line("pre40", 64'h40, TAG_WR, 64'h100);
      for (int i = 0; i < 8; i++) ev[i] = 64'h100 + 64'(i);
      read_line("rd40", 64'h40, TAG_RD, ev, -1);
      read_line("bp40", 64'h40, TAG_RD, ev, 2);

      // Line 0 preloaded, then line at word 56 wraps onto words 0..3.
      write_line("pre0", 64'h0, TAG_WR, 64'h200);
      write_line("wrap", 64'(56 * 8), TAG_WR, 64'hC0);
      for (int i = 0; i < 8; i++) ev[i] = 64'hC0 + 64'(i);
      read_line("rdwrap", 64'(56 * 8), TAG_RD, ev, -1);
      for (int i = 0; i < 4; i++) ev[i] = 64'hC4 + 64'(i);
      for (int i = 4; i < 8; i++) ev[i] = 64'h200 + 64'(i);
      read_line("rd0", 64'h0, TAG_RD, ev, -1);

      write_line("wr80", 64'h80, TAG_WR, 64'hA0);
      for (int i = 0; i < 8; i++) ev[i] = 64'hA0 + 64'(i);
      read_line("rd80", 64'h80, TAG_RD, ev, -1);

      // Non-memory device: zeros on read, writes discarded.
      for (int i = 0; i < 8; i++) ev[i] = 64'h0;
      read_line("nmrd", 64'h40, TAG_NRD, ev, -1);
      write_line("nmwr", 64'h40, TAG_NWR, 64'hDEAD00);
      for (int i = 0; i < 8; i++) ev[i] = 64'h100 + 64'(i);
      read_line("rd40b", 64'h40, TAG_RD, ev, -1);

      // Hold reqcyc through a burst, reset while beat 4 is shown.
      acks  = 0;
      beats = 0;
      n     = 0;
      bus_respack = 1'b1;
      bus_reqcyc  = 1'b1;
      bus_req     = 64'h80;
      bus_reqtag  = TAG_RD;
      @(negedge clk);
      while (beats < 4 && n < 40) begin
         if (bus_reqack) acks++;
         if (bus_respcyc) beats++;
         step();
         @(negedge clk);
         n++;
      end
      chk("busy_beat4_cyc", 64'(bus_respcyc), 64'd1);
      chk("busy_beat4_data", bus_resp, 64'hA4);
      chk("busy_single_ack", 64'(acks), 64'd1);
      reset = 1'b1;
      step();
      @(negedge clk);
      chk("rst_mid_cyc", 64'(bus_respcyc), 64'd0);
      chk("rst_mid_ack", 64'(bus_reqack), 64'd0);
      reset      = 1'b0;
      bus_reqcyc = 1'b0;
      step();
      for (int i = 0; i < 8; i++) ev[i] = 64'hA0 + 64'(i);
      read_line("after_rst", 64'h80, TAG_RD, ev, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
